// File: rtl/msk_aes_host_driver_pkg.sv
// Shared definitions for the masked AES host driver.
//   state_t : driver FSM states
//   CNT_W   : width of the BUSY watchdog counter (TIMEOUT is at most 255)
//   idx()   : position of share i of bit j in a d-share bus
package msk_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int CNT_W = 8;

    function automatic int idx(input int d, input int j, input int i);
        return d * j + i;
    endfunction

endpackage

// File: rtl/msk_aes_host_driver_if.sv
// Handshake and share buses between the host driver and the masked AES core.
//   core_valid_in     : driver -> core, launch request
//   core_ready        : core -> driver, request fetched this cycle
//   core_cipher_valid : core -> driver, one-cycle completion pulse
//   sh_plaintext/key  : driver -> core, d-share buses
//   sh_ciphertext     : core -> driver, d-share bus
interface msk_aes_host_driver_if #(
    parameter int D = 2
);
    logic               core_valid_in;
    logic               core_ready;
    logic               core_cipher_valid;
    logic [128*D-1:0]   sh_plaintext;
    logic [128*D-1:0]   sh_key;
    logic [128*D-1:0]   sh_ciphertext;

    modport master (
        output core_valid_in, sh_plaintext, sh_key,
        input  core_ready, core_cipher_valid, sh_ciphertext
    );

    modport slave (
        input  core_valid_in, sh_plaintext, sh_key,
        output core_ready, core_cipher_valid, sh_ciphertext
    );
endinterface

// File: rtl/msk_aes_host_driver_unmask.sv
// Combinational recombination of a Boolean-shared bus.
//   sh_in : count bits, d shares each, share i of bit j at d*j+i
//   plain : XOR of all shares of each bit
module msk_unmask
    import msk_host_pkg::*;
#(
    parameter int d     = 2,
    parameter int count = 128
) (
    input  logic [count*d-1:0] sh_in,
    output logic [count-1:0]   plain
);

    always_comb begin
        plain = '0;
        for (int j = 0; j < count; j++) begin
            for (int i = 0; i < d; i++) begin
                plain[j] = plain[j] ^ sh_in[idx(d, j, i)];
            end
        end
    end

endmodule

// File: rtl/msk_aes_host_driver.sv
// Host-side driver for the masked AES-128 core: shares plaintext/key with
// host-supplied masks, launches one encryption, recombines the shared
// ciphertext and returns it on a valid/ready port. A watchdog ends the wait
// with error=1 if the core never completes.
//   clk, nrst            : clock, async active-low reset
//   in_valid/in_ready    : host request handshake (plaintext, key, rnd_mask)
//   rnd_mask             : low 128*(d-1) bits mask plaintext, high bits mask key
//   core                 : interface to the core (master side)
//   out_valid/out_ready  : result handshake (ciphertext, error)
//
// state | meaning
// IDLE  | waiting for a host request, in_ready=1
// LOAD  | shares presented, core_valid_in=1 until core_ready
// BUSY  | core running, watchdog counting
// DONE  | result presented until out_ready
module msk_aes_host_driver
    import msk_host_pkg::*;
#(
    parameter int d       = 2,
    parameter int TIMEOUT = 80
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           plaintext,
    input  logic [127:0]           key,
    input  logic [256*(d-1)-1:0]   rnd_mask,
    msk_aes_host_driver_if.master  core,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           ciphertext,
    output logic                   error
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state;
    logic [128*d-1:0]    sh_pt_q;
    logic [128*d-1:0]    sh_key_q;
    logic [128*d-1:0]    sh_pt_d;
    logic [128*d-1:0]    sh_key_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [127:0]        ct_q;
    logic [127:0]        ct_plain;
    logic                err_q;
    logic                in_ready_q;
    logic                cvi_q;
    logic                out_valid_q;
    logic                acc_pt;
    logic                acc_key;

    // Shares 1..d-1 are the raw masks; share 0 carries the value XOR all masks.
    always_comb begin
        sh_pt_d  = '0;
        sh_key_d = '0;
        acc_pt   = 1'b0;
        acc_key  = 1'b0;
        for (int j = 0; j < 128; j++) begin
            acc_pt  = plaintext[j];
            acc_key = key[j];
            for (int i = 1; i < d; i++) begin
                sh_pt_d[idx(d, j, i)]  = rnd_mask[(i-1)*128 + j];
                sh_key_d[idx(d, j, i)] = rnd_mask[128*(d-1) + (i-1)*128 + j];
                acc_pt  = acc_pt  ^ rnd_mask[(i-1)*128 + j];
                acc_key = acc_key ^ rnd_mask[128*(d-1) + (i-1)*128 + j];
            end
            sh_pt_d[idx(d, j, 0)]  = acc_pt;
            sh_key_d[idx(d, j, 0)] = acc_key;
        end
    end

    msk_unmask #(
        .d     (d),
        .count (128)
    ) u_unmask (
        .sh_in (core.sh_ciphertext),
        .plain (ct_plain)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            sh_pt_q     <= '0;
            sh_key_q    <= '0;
            cnt_q       <= '0;
            ct_q        <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            cvi_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_pt_q    <= sh_pt_d;
                        sh_key_q   <= sh_key_d;
                        in_ready_q <= 1'b0;
                        cvi_q      <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    // Shares live only until the core has fetched them.
                    if (core.core_ready) begin
                        sh_pt_q  <= '0;
                        sh_key_q <= '0;
                        cnt_q    <= '0;
                        cvi_q    <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Completion takes priority over a coincident timeout.
                    if (core.core_cipher_valid) begin
                        ct_q        <= ct_plain;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else if (cnt_q == TO_LAST) begin
                        ct_q        <= '0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        ct_q        <= '0;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready           = in_ready_q;
    assign core.core_valid_in = cvi_q;
    assign core.sh_plaintext  = sh_pt_q;
    assign core.sh_key        = sh_key_q;
    assign out_valid          = out_valid_q;
    assign ciphertext         = ct_q;
    assign error              = err_q;

endmodule

// File: tb/tb_msk_aes_host_driver.sv
module tb_msk_aes_host_driver;

    localparam int TO0 = 10;
    localparam int TO1 = 80;

    localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    logic         in_valid_a [2];
    logic         in_ready_a [2];
    logic         out_valid_a[2];
    logic         out_ready_a[2];
    logic         err_a      [2];
    logic         cvi_a      [2];
    logic [127:0] pt_a       [2];
    logic [127:0] key_a      [2];
    logic [127:0] ct_a       [2];
    logic [511:0] mask_a     [2];
    logic [383:0] shpt_a     [2];
    logic [383:0] shkey_a    [2];
    int           rdly       [2];
    int           lat        [2];
    bit           never      [2];

    int checks = 0;
    int errors = 0;

    // Stand-in for the AES core: real answers for the FIPS vectors, an
    // arbitrary fixed mixing of pt/key otherwise.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        if (k == C1K && pt == C1P) return C1C;
        if (k == BK && pt == BP) return BC;
        return pt ^ {k[63:0], k[127:64]} ^ 128'ha5a5_0f0f_3c3c_9696_5a5a_f0f0_c3c3_6969;
    endfunction

    function automatic logic [127:0] recomb(input logic [383:0] v, input int dd);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 128; j++)
            for (int i = 0; i < dd; i++)
                r[j] = r[j] ^ v[dd*j + i];
        return r;
    endfunction

    function automatic logic [383:0] rnd384();
        logic [383:0] r;
        for (int k = 0; k < 12; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Random dd-share sharing of x.
    function automatic logic [383:0] mk_share(input logic [127:0] x, input int dd);
        logic [383:0] s;
        logic b;
        s = rnd384();
        for (int j = 0; j < 128; j++) begin
            b = x[j];
            for (int i = 1; i < dd; i++) b = b ^ s[dd*j + i];
            s[dd*j] = b;
        end
        return s;
    endfunction

    // Expected sharing from the host value and the mask words.
    function automatic logic [383:0] split(input logic [127:0] x, input logic [511:0] m,
                                           input int dd, input bit is_key);
        logic [383:0] s;
        logic b;
        int base;
        s = '0;
        base = is_key ? 128*(dd-1) : 0;
        for (int j = 0; j < 128; j++) begin
            b = x[j];
            for (int i = 1; i < dd; i++) begin
                s[dd*j + i] = m[base + (i-1)*128 + j];
                b = b ^ m[base + (i-1)*128 + j];
            end
            s[dd*j] = b;
        end
        return s;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D  = (g == 0) ? 2 : 3;
        localparam int TO = (g == 0) ? TO0 : TO1;

        msk_aes_host_driver_if #(.D(D)) cif();

        logic             cv;
        logic [128*D-1:0] shct;
        logic [127:0]     res;
        logic [127:0]     fetch_res;
        int               rc;
        int               lc;

        msk_aes_host_driver #(
            .d       (D),
            .TIMEOUT (TO)
        ) dut (
            .clk        (clk),
            .nrst       (nrst),
            .in_valid   (in_valid_a[g]),
            .in_ready   (in_ready_a[g]),
            .plaintext  (pt_a[g]),
            .key        (key_a[g]),
            .rnd_mask   (mask_a[g][256*(D-1)-1:0]),
            .core       (cif),
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready_a[g]),
            .ciphertext (ct_a[g]),
            .error      (err_a[g])
        );

        assign cvi_a[g]              = cif.core_valid_in;
        assign shpt_a[g]             = 384'(cif.sh_plaintext);
        assign shkey_a[g]            = 384'(cif.sh_key);
        assign cif.core_ready        = cif.core_valid_in && (rc >= rdly[g]);
        assign cif.core_cipher_valid = cv;
        assign cif.sh_ciphertext     = shct;
        assign fetch_res = aes_ref(recomb(shpt_a[g], D), recomb(shkey_a[g], D));

        // Core model: fetch after rdly stall cycles, pulse cipher_valid lat
        // cycles into BUSY (BUSY counter == lat), junk on the bus otherwise.
        always @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                rc   <= 0;
                lc   <= 0;
                cv   <= 1'b0;
                shct <= '0;
                res  <= '0;
            end else begin
                cv   <= 1'b0;
                shct <= (128*D)'(rnd384());
                if (cif.core_valid_in && !cif.core_ready) rc <= rc + 1;
                else rc <= 0;
                if (cif.core_valid_in && cif.core_ready) begin
                    res <= fetch_res;
                    if (!never[g]) begin
                        if (lat[g] == 0) begin
                            cv   <= 1'b1;
                            shct <= (128*D)'(mk_share(fetch_res, D));
                        end else begin
                            lc <= lat[g];
                        end
                    end
                end else if (lc != 0) begin
                    if (lc == 1) begin
                        cv   <= 1'b1;
                        shct <= (128*D)'(mk_share(res, D));
                    end
                    lc <= lc - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int g, input logic [127:0] pt, input logic [127:0] k,
                           input int rd, input int l, input bit nv, input int hold);
        logic [511:0] m;
        logic [383:0] ept, ekey;
        logic [127:0] e_ct;
        bit           e_err;
        int           n, to, dd, busy_exp;
        to = (g == 0) ? TO0 : TO1;
        dd = (g == 0) ? 2 : 3;
        rdly[g] = rd; lat[g] = l; never[g] = nv;
        for (int q = 0; q < 16; q++) m[32*q +: 32] = $urandom;
        ept  = split(pt, m, dd, 1'b0);
        ekey = split(k, m, dd, 1'b1);
        e_err = nv || (l >= to);
        e_ct  = e_err ? 128'h0 : aes_ref(pt, k);
        busy_exp = e_err ? to : l + 1;

        chk("idle_in_ready", 384'(in_ready_a[g]), 384'(1));
        pt_a[g] = pt; key_a[g] = k; mask_a[g] = m; in_valid_a[g] = 1'b1;
        step();
        in_valid_a[g] = 1'b0;
        pt_a[g] = rnd128(); key_a[g] = rnd128();
        for (int q = 0; q < 16; q++) mask_a[g][32*q +: 32] = $urandom;

        chk("load_valid_in", 384'(cvi_a[g]), 384'(1));
        chk("load_in_ready", 384'(in_ready_a[g]), 384'(0));
        chk("sh_plaintext", shpt_a[g], ept);
        chk("sh_key", shkey_a[g], ekey);

        n = 1;
        while (cvi_a[g] === 1'b1 && n < 60) begin
            step();
            if (cvi_a[g] === 1'b1) begin
                n++;
                chk("load_hold_pt", shpt_a[g], ept);
            end
        end
        chk("load_cycles", 384'(n), 384'(rd + 1));
        chk("fetch_clears_pt", shpt_a[g], 384'(0));
        chk("fetch_clears_key", shkey_a[g], 384'(0));
        chk("busy_ct_zero", 384'(ct_a[g]), 384'(0));

        n = 1;
        while (out_valid_a[g] !== 1'b1 && n < 400) begin
            step();
            if (out_valid_a[g] !== 1'b1) n++;
        end
        chk("busy_cycles", 384'(n), 384'(busy_exp));
        chk("out_valid", 384'(out_valid_a[g]), 384'(1));
        chk("ciphertext", 384'(ct_a[g]), 384'(e_ct));
        chk("error", 384'(err_a[g]), 384'(e_err));
        chk("done_in_ready", 384'(in_ready_a[g]), 384'(0));

        for (int h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 384'(out_valid_a[g]), 384'(1));
            chk("hold_ct", 384'(ct_a[g]), 384'(e_ct));
            chk("hold_err", 384'(err_a[g]), 384'(e_err));
        end
        out_ready_a[g] = 1'b1;
        step();
        out_ready_a[g] = 1'b0;
        chk("post_valid", 384'(out_valid_a[g]), 384'(0));
        chk("post_ct", 384'(ct_a[g]), 384'(0));
        chk("post_in_ready", 384'(in_ready_a[g]), 384'(1));
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            chk({tag, "_in_ready"}, 384'(in_ready_a[g]), 384'(1));
            chk({tag, "_valid_in"}, 384'(cvi_a[g]), 384'(0));
            chk({tag, "_out_valid"}, 384'(out_valid_a[g]), 384'(0));
            chk({tag, "_ct"}, 384'(ct_a[g]), 384'(0));
            chk({tag, "_err"}, 384'(err_a[g]), 384'(0));
            chk({tag, "_sh_pt"}, shpt_a[g], 384'(0));
            chk({tag, "_sh_key"}, shkey_a[g], 384'(0));
        end
    endtask

    // Assert nrst between clock edges, check outputs before any edge, release.
    task automatic async_reset();
        #3;
        nrst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        step();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        nrst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            in_valid_a[g] = 1'b0; out_ready_a[g] = 1'b0;
            pt_a[g] = '0; key_a[g] = '0; mask_a[g] = '0;
            rdly[g] = 0; lat[g] = 0; never[g] = 1'b0;
        end
        step();
        check_reset_vals("in_rst");
        step();
        nrst = 1'b1;
        step();
        check_reset_vals("post_rst");

        run_txn(0, C1P, C1K, 0, 5, 1'b0, 0);
        run_txn(1, BP, BK, 1, 20, 1'b0, 5);
        run_txn(0, rnd128(), rnd128(), 4, 3, 1'b0, 1);
        run_txn(0, rnd128(), rnd128(), 0, 0, 1'b1, 2);
        run_txn(0, C1P, C1K, 2, TO0 - 1, 1'b0, 0);
        run_txn(0, rnd128(), rnd128(), 0, TO0, 1'b0, 1);
        run_txn(0, rnd128(), rnd128(), 1, 0, 1'b0, 0);

        for (int r = 0; r < 6; r++)
            run_txn(0, rnd128(), rnd128(), $urandom_range(0, 4), $urandom_range(0, 12),
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
        for (int r = 0; r < 3; r++)
            run_txn(1, rnd128(), rnd128(), $urandom_range(0, 3), $urandom_range(0, 40),
                    1'b0, $urandom_range(0, 3));

        // Reset while BUSY, then a clean request.
        rdly[0] = 0; lat[0] = 0; never[0] = 1'b1;
        pt_a[0] = C1P; key_a[0] = C1K; mask_a[0] = {rnd384(), rnd128()};
        in_valid_a[0] = 1'b1;
        step();
        in_valid_a[0] = 1'b0;
        step();
        step();
        chk("busy_before_rst", 384'({cvi_a[0], in_ready_a[0], out_valid_a[0]}), 384'(0));
        async_reset();
        run_txn(0, C1P, C1K, 0, 4, 1'b0, 0);

        // Reset while LOAD with live shares.
        rdly[0] = 20; lat[0] = 0; never[0] = 1'b0;
        pt_a[0] = rnd128(); key_a[0] = rnd128(); mask_a[0] = {rnd384(), rnd128()};
        in_valid_a[0] = 1'b1;
        step();
        in_valid_a[0] = 1'b0;
        step();
        chk("load_before_rst", 384'(cvi_a[0]), 384'(1));
        async_reset();
        run_txn(0, C1P, C1K, 0, 2, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
